// File: rtl/huffman_pkg.sv
// huffman_pkg: shared types and default parameters for the Huffman decoder
//   W_DEF/IW_DEF/MAXL_DEF/DEPTH_DEF : default symbol, input word, max code length, table depth
//   state_t : IDLE / CONF / RUN
//   entry_t : one table entry {valid, len, code, sym} at default widths
package huffman_pkg;
  localparam int W_DEF = 8;
  localparam int IW_DEF = 8;
  localparam int MAXL_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int LW_DEF = $clog2(MAXL_DEF + 1);
  typedef enum logic [1:0] {IDLE, CONF, RUN} state_t;
  typedef struct packed {
    logic valid;
    logic [LW_DEF-1:0] len;
    logic [MAXL_DEF-1:0] code;
    logic [W_DEF-1:0] sym;
  } entry_t;
endpackage

// File: rtl/huffman_match.sv
// huffman_match: DEPTH-way code comparator with lowest-index priority
//   i_top   : top MAXL bits of the bit buffer (MSB = next bit)
//   i_cnt   : number of valid bits in the buffer
//   i_valid/i_len/i_code : table contents, codes right-aligned
//   o_hit/o_idx/o_len    : match found, winning entry, its code length
module huffman_match
  import huffman_pkg::*;
#(
  parameter int MAXL = MAXL_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW = 5,
  localparam int LW = $clog2(MAXL + 1),
  localparam int XW = $clog2(DEPTH)
) (
  input  logic [MAXL-1:0] i_top,
  input  logic [CW-1:0] i_cnt,
  input  logic [DEPTH-1:0] i_valid,
  input  logic [DEPTH-1:0][LW-1:0] i_len,
  input  logic [DEPTH-1:0][MAXL-1:0] i_code,
  output logic o_hit,
  output logic [XW-1:0] o_idx,
  output logic [LW-1:0] o_len
);
  logic [DEPTH-1:0] w_m;
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    logic [MAXL-1:0] w_mask;
    assign w_mask = ~({MAXL{1'b1}} << i_len[g]);
    // right-shift brings the leading len bits of the buffer down to align with the code
    assign w_m[g] = i_valid[g] && CW'(i_len[g]) <= i_cnt &&
                    (i_top >> (LW'(MAXL) - i_len[g])) == (i_code[g] & w_mask);
  end
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (w_m[i]) begin
        o_hit = 1'b1;
        o_idx = XW'(i);
      end
  end
  assign o_len = i_len[o_idx];
endmodule

// File: rtl/huffman_dec_param.sv
// huffman_dec_param: table-driven Huffman decoder, MSB-first packed input, one symbol per match
//   clk, rst (async, active-high)
//   d_req/d_in/en_in/ready_in : input word request and stream
//   d_conf/h_conf/w_conf/en_conf/new_conf : run-time table load
//   d_out/en_out/out_rdy : decoded symbol with valid/ready handshake
//   err : sticky invalid-code / overflow flag, present only when HUFF_ERR_EN is defined
module huffman_dec_param
  import huffman_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int IW = IW_DEF,
  parameter int MAXL = MAXL_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic d_req,
  input  logic [IW-1:0] d_in,
  input  logic en_in,
  input  logic ready_in,
  input  logic [W-1:0] d_conf,
  input  logic [MAXL-1:0] h_conf,
  input  logic [$clog2(MAXL+1)-1:0] w_conf,
  input  logic en_conf,
  input  logic new_conf,
  output logic [W-1:0] d_out,
  output logic en_out,
  input  logic out_rdy
`ifdef HUFF_ERR_EN
  ,
  output logic err
`endif
);
  localparam int LW = $clog2(MAXL + 1);
  localparam int BW = 3 * IW;
  localparam int CW = $clog2(BW + 1);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int XW = $clog2(DEPTH);
  state_t r_state;
  logic [BW-1:0] r_buf;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_ptr;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0][LW-1:0] r_len;
  logic [DEPTH-1:0][MAXL-1:0] r_code;
  logic [DEPTH-1:0][W-1:0] r_sym;
  logic [W-1:0] r_d_out;
  logic r_en_out;
  logic w_run, w_hit, w_take, w_drop, w_acc, w_wr;
  logic [XW-1:0] w_idx;
  logic [LW-1:0] w_len;
  logic [CW-1:0] w_sh, w_cnt_s, w_cnt_n;
  logic [BW-1:0] w_buf_n;
  huffman_match #(.MAXL(MAXL), .DEPTH(DEPTH), .CW(CW)) u_match (
    .i_top(r_buf[BW-1 -: MAXL]),
    .i_cnt(r_cnt),
    .i_valid(r_valid),
    .i_len(r_len),
    .i_code(r_code),
    .o_hit(w_hit),
    .o_idx(w_idx),
    .o_len(w_len)
  );
  assign w_run = r_state == RUN;
  assign d_req = w_run && ready_in && r_cnt <= CW'(IW);
  // a match only consumes bits when the output register can take the symbol
  assign w_take = w_run && w_hit && (!r_en_out || out_rdy);
  assign w_drop = w_run && !w_hit && r_cnt >= CW'(MAXL);
  assign w_acc = w_run && en_in && r_cnt <= CW'(2 * IW);
  assign w_sh = w_take ? CW'(w_len) : (w_drop ? CW'(1) : '0);
  assign w_cnt_s = r_cnt - w_sh;
  // new word lands directly below the bits that survive this cycle's shift
  assign w_buf_n = (r_buf << w_sh) | (w_acc ? {d_in, {(2 * IW){1'b0}}} >> w_cnt_s : '0);
  assign w_cnt_n = w_cnt_s + (w_acc ? CW'(IW) : '0);
  assign w_wr = en_conf && w_conf != '0 && w_conf <= LW'(MAXL) && r_ptr < PW'(DEPTH);
  assign d_out = r_d_out;
  assign en_out = r_en_out;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_buf <= '0;
      r_cnt <= '0;
      r_ptr <= '0;
      r_valid <= '0;
      r_len <= '0;
      r_code <= '0;
      r_sym <= '0;
      r_d_out <= '0;
      r_en_out <= 1'b0;
    end else if (new_conf) begin
      r_state <= CONF;
      r_buf <= '0;
      r_cnt <= '0;
      r_ptr <= '0;
      r_valid <= '0;
      r_en_out <= 1'b0;
    end else if (r_state == CONF) begin
      if (w_wr) begin
        r_valid[r_ptr[XW-1:0]] <= 1'b1;
        r_len[r_ptr[XW-1:0]] <= w_conf;
        r_code[r_ptr[XW-1:0]] <= h_conf;
        r_sym[r_ptr[XW-1:0]] <= d_conf;
        r_ptr <= r_ptr + PW'(1);
      end
      if (ready_in && !en_conf) r_state <= RUN;
    end else if (w_run) begin
      r_buf <= w_buf_n;
      r_cnt <= w_cnt_n;
      r_en_out <= w_take || (r_en_out && !out_rdy);
      if (w_take) r_d_out <= r_sym[w_idx];
    end
`ifdef HUFF_ERR_EN
  logic w_ovf, r_err;
  assign w_ovf = w_run && en_in && r_cnt > CW'(2 * IW);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_err <= 1'b0;
    else if (new_conf) r_err <= 1'b0;
    else if (w_drop || w_ovf) r_err <= 1'b1;
  assign err = r_err;
`endif
endmodule
